lcm_unit: RTL and testbench
===========================

# lcm_unit

Sequential least-common-multiple engine built on repeated addition: the add-side counterpart of the team's subtract-based GCD datapath/controller pair. It uses the same two-operand serial load over a shared `dataIn` bus, starting on `Start`. It produces a double-width result with a held completion flag. It sits beside the GCD unit as an arithmetic coprocessor in the lab datapath. Only one multi-bit adder is in the loop. Comparator outputs steer which running multiple advances.

## Interface
- `WIDTH`, default 8: operand width; the result is `2*WIDTH` bits.

- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst_n`  input  1: reset, asynchronous and active-low.
- `Start`  input  1: sampled only in IDLE or DONE; begins operand load.
- `dataIn`  input  WIDTH: operand bus. It carries operand A in the cycle `Start` is sampled and operand B in the following cycle.
- `lcm`  output  2*WIDTH: result register, held until the next accepted `Start`.
- `done`  output  1: high while in DONE (level, not a pulse).
- `busy`  output  1: high in LOADB and CALC.
- `err`  output  1: high in DONE when either operand was zero.

## Operation
- Registers:
  - `regA`, `regB`: WIDTH bits.
  - `X`, `Y`: 2*WIDTH bits, the running multiples.
  - `lcm`: 2*WIDTH bits.
  - `state`: encodes IDLE, LOADB, CALC, DONE.
- IDLE:
  - `busy=0`, `done=0`.
  - If `Start`: `regA<=dataIn`, `X<={0,dataIn}`, go to LOADB.
- LOADB: `regB<=dataIn`, `Y<={0,dataIn}`, go to CALC. `Start` is ignored here.
- CALC evaluates one step per cycle, in priority order:
  - If `regA==0` or `regB==0`: `lcm<=0`, `err<=1`, go to DONE.
  - Else if `X==Y`: `lcm<=X`, `err<=0`, go to DONE.
  - Else if `X<Y`: `X<=X+regA` (regA zero-extended).
  - Else: `Y<=Y+regB`.
- DONE:
  - `done=1`; `lcm` and `err` are held.
  - `Start` is accepted exactly as in IDLE. On that edge `done` and `err` clear, while `lcm` holds its old value until the new result is written.
- `Start` in LOADB or CALC has no effect. There is no abort input; the only abort is reset.
- Arithmetic rules:
  - All compares are unsigned and 2*WIDTH bits wide.
  - Invariant: X is a multiple of A and Y is a multiple of B, both ≤ lcm(A,B). Therefore X+A ≤ lcm ≤ (2^WIDTH−1)², so the adder never overflows and its carry-out is unused.
- Termination is guaranteed for nonzero operands. Number of add steps: k = lcm/A + lcm/B − 2.

## Timing
- Reset (async, `rst_n=0`):
  - State goes to IDLE.
  - `lcm`, `X`, `Y`, `regA`, `regB` reset to 0.
  - `done=0`, `busy=0`, `err=0`.
  - Takes effect immediately, including mid-operation. After release, the first rising edge with `Start=1` loads A.
- Edge numbering: edge 0 is the one that samples `Start`.
  - Edge 1 loads B.
  - Edges 2..k+1 perform the adds.
  - Edge k+2 enters DONE.
  - `done` is visible after edge k+2; latency is k+2 clocks.
- Zero operand: DONE is entered at edge 2 with `err=1`.
- `busy` is high from after edge 0 through edge k+2, exclusive of DONE.
- Outputs are registered or state-decoded only; there is no combinational path from inputs to outputs.

## Test plan
- A=4, B=6, WIDTH=8: k=3, so `lcm=12`, `err=0`. `done` rises after edge 5; `busy` is high for cycles 1–4.
- A=7, B=7: k=0, so `lcm=7`, and `done` rises after edge 2.
- A=255, B=254 (no overflow check): `lcm=64770` (0xFD02), `err=0`, k=507.
- A=0, B=5: `lcm=0`, `err=1`, `done` after edge 2. Then from DONE, `Start` with A=1, B=9: `err` clears on edge 0, and `lcm=9` after k=8, i.e. 10 edges.
- A=12, B=18, with `Start` pulsed again during CALC: the pulse is ignored and `lcm=36`. Then run A=12, B=18 again and drive `rst_n=0` mid-CALC: `busy`, `done`, `err` and `lcm` go to 0 without waiting for a clock edge. After release, a fresh run with A=3, B=5 gives `lcm=15`.

Source files
------------

// File: rtl/lcm_unit.sv
// Sequential LCM engine: advances the smaller running multiple by its
// operand until the two multiples meet; one shared adder in the loop.
module lcm_unit #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               Start,
  input  logic [WIDTH-1:0]   dataIn,
  output logic [2*WIDTH-1:0] lcm,
  output logic               done,
  output logic               busy,
  output logic               err
);

  localparam int DW = 2 * WIDTH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOADB = 2'd1;
  localparam logic [1:0] S_CALC  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state;
  logic [WIDTH-1:0] regA;
  logic [WIDTH-1:0] regB;
  logic [DW-1:0]    X;
  logic [DW-1:0]    Y;
  logic             err_q;

  logic             zero_op;
  logic             eq;
  logic             x_lt_y;
  logic [DW-1:0]    add_base;
  logic [DW-1:0]    add_inc;
  logic [DW-1:0]    sum;
  logic [DW-1:0]    ext_in;

  assign ext_in  = {{WIDTH{1'b0}}, dataIn};
  assign zero_op = (regA == '0) || (regB == '0);
  assign eq      = (X == Y);
  assign x_lt_y  = (X < Y);

  // Comparator steers the single adder to the lagging multiple.
  always_comb begin
    add_base = Y;
    add_inc  = {{WIDTH{1'b0}}, regB};
    if (x_lt_y) begin
      add_base = X;
      add_inc  = {{WIDTH{1'b0}}, regA};
    end
  end

  assign sum = add_base + add_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      regA  <= '0;
      regB  <= '0;
      X     <= '0;
      Y     <= '0;
      lcm   <= '0;
      err_q <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (Start) begin
            regA  <= dataIn;
            X     <= ext_in;
            err_q <= 1'b0;
            state <= S_LOADB;
          end
        end
        S_LOADB: begin
          regB  <= dataIn;
          Y     <= ext_in;
          state <= S_CALC;
        end
        S_CALC: begin
          unique case (1'b1)
            zero_op: begin
              lcm   <= '0;
              err_q <= 1'b1;
              state <= S_DONE;
            end
            (!zero_op && eq): begin
              lcm   <= X;
              err_q <= 1'b0;
              state <= S_DONE;
            end
            (!zero_op && !eq && x_lt_y): X <= sum;
            default: Y <= sum;
          endcase
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign done = (state == S_DONE);
  assign busy = (state == S_LOADB) || (state == S_CALC);
  assign err  = err_q && (state == S_DONE);

endmodule

// File: tb/tb_lcm_unit.sv
// Bench for lcm_unit: directed and random operand pairs against an
// arithmetic gcd-based LCM model, plus reset and Start-ignore scenarios.
module tb_lcm_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Start = 1'b0;
  logic [7:0]  dataIn = '0;
  logic [15:0] lcm;
  logic        done;
  logic        busy;
  logic        err;

  int npass = 0;
  int ntotal = 0;
  logic [15:0] last_lcm = '0;

  lcm_unit #(.WIDTH(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .Start(Start),
    .dataIn(dataIn),
    .lcm(lcm),
    .done(done),
    .busy(busy),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic model(input int a, input int b,
                       output int l, output bit e, output int lat);
    int x, y, t;
    if (a == 0 || b == 0) begin
      l = 0; e = 1'b1; lat = 2;
    end else begin
      x = a; y = b;
      while (y != 0) begin
        t = x % y; x = y; y = t;
      end
      l = (a / x) * b;
      e = 1'b0;
      lat = l / a + l / b;
    end
  endtask

  task automatic run_op(input int a, input int b, input bit glitch,
                        input string nm);
    int exp_l, exp_lat, e;
    bit exp_e, bbad;
    model(a, b, exp_l, exp_e, exp_lat);
    @(negedge clk);
    Start = 1'b1;
    dataIn = a[7:0];
    @(posedge clk);
    @(negedge clk);
    ntotal++;
    if ({done, err, busy, lcm} !== {1'b0, 1'b0, 1'b1, last_lcm}) begin
      $display("FAIL %s edge0: done/err/busy/lcm=%b%b%b/%0d want 001/%0d",
               nm, done, err, busy, lcm, last_lcm);
    end else npass++;
    Start = 1'b0;
    dataIn = b[7:0];
    @(posedge clk);
    e = 1;
    bbad = 1'b0;
    while (e < 3000) begin
      @(negedge clk);
      dataIn = 8'($urandom);
      if (done) break;
      if (!busy) bbad = 1'b1;
      Start = (glitch && e == 2);
      @(posedge clk);
      e++;
    end
    Start = 1'b0;
    ntotal++;
    if (e >= 3000 || e != exp_lat) begin
      $display("FAIL %s latency: got %0d edges want %0d", nm, e, exp_lat);
    end else npass++;
    ntotal++;
    if (lcm !== 16'(exp_l)) begin
      $display("FAIL %s lcm: got %0d want %0d", nm, lcm, exp_l);
    end else npass++;
    ntotal++;
    if (err !== exp_e || busy !== 1'b0) begin
      $display("FAIL %s err/busy: got %b/%b want %b/0", nm, err, busy, exp_e);
    end else npass++;
    ntotal++;
    if (bbad) begin
      $display("FAIL %s busy_low_in_calc: got 0 want 1", nm);
    end else npass++;
    last_lcm = 16'(exp_l);
  endtask

  task automatic test_reset;
    #12;
    ntotal++;
    if ({done, busy, err, lcm} !== 19'd0) begin
      $display("FAIL reset_state: got %b%b%b/%0d want 000/0",
               done, busy, err, lcm);
    end else npass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed;
    run_op(4, 6, 1'b0, "a4_b6");
    run_op(7, 7, 1'b0, "a7_b7");
    run_op(255, 254, 1'b0, "a255_b254");
  endtask

  task automatic test_zero_then_restart;
    run_op(0, 5, 1'b0, "a0_b5");
    run_op(1, 9, 1'b0, "a1_b9");
    run_op(6, 0, 1'b0, "a6_b0");
  endtask

  task automatic test_start_ignored;
    run_op(12, 18, 1'b1, "glitch_a12_b18");
  endtask

  task automatic test_reset_mid_calc;
    @(negedge clk);
    Start = 1'b1;
    dataIn = 8'd12;
    @(negedge clk);
    Start = 1'b0;
    dataIn = 8'd18;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    ntotal++;
    if ({done, busy, err, lcm} !== 19'd0) begin
      $display("FAIL async_reset: got %b%b%b/%0d want 000/0",
               done, busy, err, lcm);
    end else npass++;
    @(negedge clk);
    rst_n = 1'b1;
    last_lcm = '0;
    run_op(3, 5, 1'b0, "after_reset_a3_b5");
  endtask

  task automatic test_random;
    int a, b;
    for (int i = 0; i < 25; i++) begin
      a = (i % 8 == 7) ? 0 : int'($urandom_range(1, 60));
      b = int'($urandom_range(1, 60));
      run_op(a, b, 1'b0, $sformatf("rand%0d_a%0d_b%0d", i, a, b));
    end
    run_op(int'($urandom_range(200, 255)), int'($urandom_range(200, 255)),
           1'b0, "rand_big");
  endtask

  task automatic test_back_to_back;
    run_op(9, 6, 1'b0, "b2b_1");
    run_op(5, 15, 1'b0, "b2b_2");
    run_op(1, 1, 1'b0, "b2b_3");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_zero_then_restart();
    test_start_ignored();
    test_reset_mid_calc();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
